// File: rtl/sym_frame_tx_pkg.sv
// rtl/sym_frame_tx_pkg.sv - shared state encoding, symbol constants and gap-load helper
package sym_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_DATA = 3'd2,
    ST_PAR  = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  localparam logic [1:0] SYM_PREAMBLE = 2'b11;
  localparam logic [1:0] SYM_IDLE     = 2'b00;

  // The gap timer counts down to zero, so it starts one below the gap length.
  function automatic logic [3:0] gap_load(input int gap);
    return (gap > 0) ? 4'(gap - 1) : 4'd0;
  endfunction

endpackage

// File: rtl/sym_frame_tx_if.sv
// rtl/sym_frame_tx_if.sv - byte-in / symbol-out bus between producer, transmitter and receiver
interface sym_tx_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic [1:0] sym;
  logic       sym_valid;
  logic       busy;

  modport master (
    output s_valid, s_data,
    input  s_ready, sym, sym_valid, busy
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, sym, sym_valid, busy
  );
endinterface

// File: rtl/sym_frame_tx_gap_timer.sv
// rtl/sym_frame_tx_gap_timer.sv - 4-bit down-counter timing the idle gap after each frame
module sym_gap_timer (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_tick,
  output logic       o_done
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_tick && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_done = (r_cnt == 4'd0);

endmodule

// File: rtl/sym_frame_tx.sv
// rtl/sym_frame_tx.sv - frames each accepted byte as preamble, four 2-bit data symbols and parity
module sym_frame_tx
  import sym_tx_pkg::*;
#(
  parameter int GAP_CYCLES = 1,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic     clk,
  input  logic     rstn,
  sym_tx_if.slave  bus
);

  localparam logic [3:0] GAP_LOAD = gap_load(GAP_CYCLES);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_cnt;
  logic [7:0] r_shift;
  logic [1:0] r_par;
  logic [1:0] w_data_sym;
  logic       w_accept;
  logic       w_gap_load;
  logic       w_gap_tick;
  logic       w_gap_done;

  // The outgoing slice always sits at the end that shifts out first.
  assign w_data_sym = MSB_FIRST ? r_shift[7:6] : r_shift[1:0];
  assign w_accept   = (r_state == ST_IDLE) && bus.s_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_gap_load    = 1'b0;
    w_gap_tick    = 1'b0;
    bus.sym       = SYM_IDLE;
    bus.sym_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.s_valid) w_next = ST_PRE;
      end
      ST_PRE: begin
        bus.sym       = SYM_PREAMBLE;
        bus.sym_valid = 1'b1;
        w_next        = ST_DATA;
      end
      ST_DATA: begin
        bus.sym       = w_data_sym;
        bus.sym_valid = 1'b1;
        if (r_cnt == 2'd3) w_next = ST_PAR;
      end
      ST_PAR: begin
        bus.sym       = r_par;
        bus.sym_valid = 1'b1;
        if (GAP_CYCLES > 0) begin
          w_next     = ST_GAP;
          w_gap_load = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_GAP: begin
        w_gap_tick = 1'b1;
        if (w_gap_done) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt   <= 2'd0;
      r_shift <= 8'h00;
      r_par   <= 2'b00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_shift <= bus.s_data;
            r_par   <= 2'b00;
            r_cnt   <= 2'd0;
          end
        end
        ST_PRE: begin
          r_cnt <= 2'd0;
        end
        ST_DATA: begin
          r_par   <= r_par ^ w_data_sym;
          r_shift <= MSB_FIRST ? {r_shift[5:0], 2'b00} : {2'b00, r_shift[7:2]};
          r_cnt   <= r_cnt + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.s_ready = (r_state == ST_IDLE);
  assign bus.busy    = (r_state != ST_IDLE);

  sym_gap_timer u_gap_timer (
    .clk        (clk),
    .rstn       (rstn),
    .i_load     (w_gap_load),
    .i_load_val (GAP_LOAD),
    .i_tick     (w_gap_tick),
    .o_done     (w_gap_done)
  );

endmodule

// File: tb/tb_sym_frame_tx.sv
// tb/tb_sym_frame_tx.sv - four parameterisations of sym_frame_tx checked against a frame-schedule model
module tb_sym_frame_tx;

  localparam int G_ARR [4] = '{1, 1, 0, 15};
  localparam bit M_ARR [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic       s_valid_a   [4];
  logic [7:0] s_data_a    [4];
  logic [1:0] sym_a       [4];
  logic       sym_valid_a [4];
  logic       busy_a      [4];
  logic       s_ready_a   [4];

  sym_tx_if if0 ();
  sym_tx_if if1 ();
  sym_tx_if if2 ();
  sym_tx_if if3 ();

  assign if0.s_valid = s_valid_a[0];
  assign if0.s_data  = s_data_a[0];
  assign if1.s_valid = s_valid_a[1];
  assign if1.s_data  = s_data_a[1];
  assign if2.s_valid = s_valid_a[2];
  assign if2.s_data  = s_data_a[2];
  assign if3.s_valid = s_valid_a[3];
  assign if3.s_data  = s_data_a[3];

  assign sym_a[0] = if0.sym;  assign sym_valid_a[0] = if0.sym_valid;
  assign busy_a[0] = if0.busy; assign s_ready_a[0] = if0.s_ready;
  assign sym_a[1] = if1.sym;  assign sym_valid_a[1] = if1.sym_valid;
  assign busy_a[1] = if1.busy; assign s_ready_a[1] = if1.s_ready;
  assign sym_a[2] = if2.sym;  assign sym_valid_a[2] = if2.sym_valid;
  assign busy_a[2] = if2.busy; assign s_ready_a[2] = if2.s_ready;
  assign sym_a[3] = if3.sym;  assign sym_valid_a[3] = if3.sym_valid;
  assign busy_a[3] = if3.busy; assign s_ready_a[3] = if3.s_ready;

  sym_frame_tx #(.GAP_CYCLES(1),  .MSB_FIRST(1'b1)) u0 (.clk(clk), .rstn(rstn), .bus(if0.slave));
  sym_frame_tx #(.GAP_CYCLES(1),  .MSB_FIRST(1'b0)) u1 (.clk(clk), .rstn(rstn), .bus(if1.slave));
  sym_frame_tx #(.GAP_CYCLES(0),  .MSB_FIRST(1'b1)) u2 (.clk(clk), .rstn(rstn), .bus(if2.slave));
  sym_frame_tx #(.GAP_CYCLES(15), .MSB_FIRST(1'b1)) u3 (.clk(clk), .rstn(rstn), .bus(if3.slave));

  int n_cmp = 0;
  int n_err = 0;

  // Model: position within the current frame schedule (0 = idle, 1 = preamble,
  // 2..5 = data, 6 = parity, 7.. = gap) and the byte captured at the handshake.
  int         m_k     [4];
  logic [7:0] m_b     [4];
  int         hs_cnt  [4];
  int         hs_edge [4][$];
  logic [1:0] cap_q   [4][$];
  int         edge_cnt = 0;
  int         run     [4];
  int         gap_len [4];
  int         vlow    [4];
  int         between [4];

  function automatic logic [4:0] exp_out(input int k, input logic [7:0] b, input bit msb);
    logic [1:0] s [4];
    for (int j = 0; j < 4; j++)
      s[j] = msb ? 2'((b >> (6 - 2 * j)) & 8'h03) : 2'((b >> (2 * j)) & 8'h03);
    if (k == 0)      return {2'b00, 1'b0, 1'b0, 1'b1};
    else if (k == 1) return {2'b11, 1'b1, 1'b1, 1'b0};
    else if (k <= 5) return {s[k - 2], 1'b1, 1'b1, 1'b0};
    else if (k == 6) return {s[0] ^ s[1] ^ s[2] ^ s[3], 1'b1, 1'b1, 1'b0};
    else             return {2'b00, 1'b0, 1'b1, 1'b0};
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) begin
        m_k[i] = 0;
        cap_q[i].delete();
      end
    end else begin
      edge_cnt++;
      for (int i = 0; i < 4; i++) begin
        if (m_k[i] == 0) begin
          if (s_valid_a[i]) begin
            m_k[i] = 1;
            m_b[i] = s_data_a[i];
            hs_cnt[i]++;
            hs_edge[i].push_back(edge_cnt);
          end
        end else if (m_k[i] == 6 + G_ARR[i]) begin
          m_k[i] = 0;
        end else begin
          m_k[i]++;
        end
      end
    end
  end

  always @(posedge clk) begin
    logic [4:0] e;
    logic [4:0] act;
    #1;
    for (int i = 0; i < 4; i++) begin
      e   = exp_out(m_k[i], m_b[i], M_ARR[i]);
      act = {sym_a[i], sym_valid_a[i], busy_a[i], s_ready_a[i]};
      n_cmp++;
      if (act !== e) begin
        n_err++;
        $display("FAIL cycle u%0d edge %0d: got {sym,valid,busy,ready}=%b want %b", i, edge_cnt, act, e);
      end
      if (sym_valid_a[i]) cap_q[i].push_back(sym_a[i]);
      if (busy_a[i] && !sym_valid_a[i]) begin
        run[i]++;
      end else begin
        if (!busy_a[i] && run[i] > 0) gap_len[i] = run[i];
        run[i] = 0;
      end
      if (sym_valid_a[i]) begin
        if (vlow[i] > 0) between[i] = vlow[i];
        vlow[i] = 0;
      end else begin
        vlow[i]++;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_frame(input int i, input logic [11:0] exp, input string name);
    logic [11:0] got;
    got = 12'h000;
    if (cap_q[i].size() < 6) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: only %0d symbols captured, want 6", name, cap_q[i].size());
    end else begin
      for (int j = 0; j < 6; j++) got = {got[9:0], cap_q[i].pop_front()};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s: got symbols %b want %b", name, got, exp);
      end
    end
  endtask

  task automatic wait_hs(input int i, input int target, input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (hs_cnt[i] >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({name, "_timeout"}, hs_cnt[i], target);
  endtask

  task automatic wait_idle(input int i, input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #2;
      if (m_k[i] == 0 && s_ready_a[i]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({name, "_idle_timeout"}, 0, 1);
  endtask

  task automatic send(input int i, input logic [7:0] b, input string name);
    int h;
    h = hs_cnt[i];
    @(negedge clk);
    s_valid_a[i] = 1'b1;
    s_data_a[i]  = b;
    wait_hs(i, h + 1, name);
    @(negedge clk);
    s_valid_a[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int h;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      s_valid_a[i] = 1'b0;
      s_data_a[i]  = 8'h00;
      m_k[i] = 0; m_b[i] = 8'h00; hs_cnt[i] = 0;
      run[i] = 0; gap_len[i] = 0; vlow[i] = 0; between[i] = 0;
    end
    #1 rstn = 1'b0;
    #2;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_ready_u%0d", i), int'(s_ready_a[i]), 1);
      check($sformatf("rst_busy_u%0d", i), int'(busy_a[i]), 0);
      check($sformatf("rst_valid_u%0d", i), int'(sym_valid_a[i]), 0);
    end
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;

    send(0, 8'hB4, "b4_msb");
    wait_idle(0, "b4_msb");
    check_frame(0, 12'b11_10_11_01_00_00, "b4_msb_frame");
    check("b4_msb_gap", gap_len[0], 1);
    check("b4_msb_ready_edge", edge_cnt - hs_edge[0][0], 7);

    send(1, 8'hB4, "b4_lsb");
    wait_idle(1, "b4_lsb");
    check_frame(1, 12'b11_00_01_11_10_00, "b4_lsb_frame");

    send(0, 8'hC1, "c1_msb");
    wait_idle(0, "c1_msb");
    check_frame(0, 12'b11_11_00_00_01_10, "c1_msb_frame");

    h = hs_cnt[2];
    @(negedge clk);
    s_valid_a[2] = 1'b1;
    s_data_a[2]  = 8'h01;
    wait_hs(2, h + 1, "b2b_first");
    @(negedge clk);
    s_data_a[2] = 8'h02;
    wait_hs(2, h + 2, "b2b_second");
    @(negedge clk);
    s_valid_a[2] = 1'b0;
    wait_idle(2, "b2b");
    check_frame(2, 12'b11_00_00_00_01_01, "b2b_frame_01");
    check_frame(2, 12'b11_00_00_00_10_10, "b2b_frame_02");
    check("b2b_hs_spacing", hs_edge[2][h + 1] - hs_edge[2][h], 7);
    check("b2b_idle_between", between[2], 1);

    h = hs_cnt[0];
    @(negedge clk);
    s_valid_a[0] = 1'b1;
    s_data_a[0]  = 8'hA5;
    wait_hs(0, h + 1, "mid_change");
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      s_valid_a[0] = ~s_valid_a[0];
      s_data_a[0]  = 8'h5A + 8'(j);
    end
    @(negedge clk);
    s_valid_a[0] = 1'b0;
    wait_idle(0, "mid_change");
    check("mid_change_hs_count", hs_cnt[0] - h, 1);
    check_frame(0, 12'b11_10_10_01_01_00, "mid_change_frame");

    @(negedge clk);
    s_valid_a[0] = 1'b1;
    s_data_a[0]  = 8'hC1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (m_k[0] == 3) begin
        ok = 1'b1;
        break;
      end
    end
    s_valid_a[0] = 1'b0;
    if (!ok) check("abort_reach_data2", 0, 1);
    #1 rstn = 1'b0;
    #1;
    check("abort_valid", int'(sym_valid_a[0]), 0);
    check("abort_busy", int'(busy_a[0]), 0);
    check("abort_ready", int'(s_ready_a[0]), 1);
    check("abort_sym", int'(sym_a[0]), 0);
    @(negedge clk); @(negedge clk);
    h = hs_cnt[0];
    rstn = 1'b1;
    s_valid_a[0] = 1'b1;
    s_data_a[0]  = 8'hC1;
    @(posedge clk); #1;
    check("first_hs_after_reset", hs_cnt[0] - h, 1);
    @(negedge clk);
    s_valid_a[0] = 1'b0;
    wait_idle(0, "post_reset");
    check_frame(0, 12'b11_11_00_00_01_10, "post_reset_frame");

    send(3, 8'h3C, "gap15");
    wait_idle(3, "gap15");
    check_frame(3, 12'b11_00_11_11_00_00, "gap15_frame");
    check("gap15_len", gap_len[3], 15);

    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 4; i++)
      check($sformatf("stray_symbols_u%0d", i), cap_q[i].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
